// File: rtl/peak_batch_ctrl_if.sv
// -----------------------------------------------------------------------------
// peak_batch_ctrl_if
// Streaming bundle used both for the FFT stream entering peak_batch_ctrl and
// for the stream forwarded to peak_detect.
//   sop    first entry of a frame
//   eop    last entry of a frame
//   valid  entry valid
//   re/im  real/imaginary sample, DATA_WIDTH bits each
// Modports:
//   master  drives the stream (the producer side)
//   slave   receives the stream (the consumer side)
// -----------------------------------------------------------------------------
interface peak_batch_ctrl_if #(
    parameter int DATA_WIDTH = 20
);
    logic                  sop;
    logic                  eop;
    logic                  valid;
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;

    modport master (output sop, output eop, output valid, output re, output im);
    modport slave  (input  sop, input  eop, input  valid, input  re, input  im);
endinterface

// File: rtl/peak_batch_ctrl.sv
// -----------------------------------------------------------------------------
// peak_batch_ctrl
// Batch sequencer in front of peak_detect. Only whole, well-formed frames of
// BATCH_SIZE entries reach the detector. The detector is cleared between
// batches and the sequencer waits for its peak report (or a timeout) before
// accepting the next frame. Frames arriving while busy are dropped; malformed
// frames are aborted and flagged.
//
// Ports:
//   clk            clock
//   reset_n        asynchronous active-low reset
//   enable         high: accept batches
//   in_if          FFT input stream (slave)
//   det_if         stream forwarded to peak_detect, 1-cycle latency (master)
//   det_reset      synchronous active-high reset to peak_detect
//   det_src_valid  peak_detect source_valid
//   det_src_eop    peak_detect source_eop
//   busy           high while loading a frame or draining the detector
//   batch_done     1-cycle pulse: detector report complete
//   frame_err      1-cycle pulse: frame aborted or drain timeout
//   frame_drop     1-cycle pulse: frame discarded because the detector is busy
//   frame_cnt/drop_cnt/err_cnt  saturating statistics (PEAK_BATCH_STATS_EN)
//
// Optional feature: define PEAK_BATCH_STATS_EN to add the statistics counters.
// All outputs are registered.
// -----------------------------------------------------------------------------
module peak_batch_ctrl #(
    parameter int BATCH_SIZE    = 1024,
    parameter int DATA_WIDTH    = 20,
    parameter int DRAIN_TIMEOUT = 4096
`ifdef PEAK_BATCH_STATS_EN
    ,
    parameter int CNT_WIDTH     = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    peak_batch_ctrl_if.slave      in_if,
    peak_batch_ctrl_if.master     det_if,
    output logic                  det_reset,
    input  logic                  det_src_valid,
    input  logic                  det_src_eop,
    output logic                  busy,
    output logic                  batch_done,
    output logic                  frame_err,
    output logic                  frame_drop
`ifdef PEAK_BATCH_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
`endif
);

    localparam int POS_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BATCH_SIZE - 1);
    localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ARMED = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [POS_W-1:0]      pos_r;
    logic [POS_W-1:0]      pos_nx_s;
    logic [TMR_W-1:0]      timer_r;
    logic [TMR_W-1:0]      timer_nx_s;
    logic                  fwd_s;
    logic                  done_s;
    logic                  err_s;
    logic                  drop_s;
    logic                  sop_beat_s;
    logic                  det_eop_s;

    logic                  det_reset_r;
    logic                  busy_r;
    logic                  batch_done_r;
    logic                  frame_err_r;
    logic                  frame_drop_r;
    logic                  det_sop_r;
    logic                  det_eop_r;
    logic                  det_valid_r;
    logic [DATA_WIDTH-1:0] det_re_r;
    logic [DATA_WIDTH-1:0] det_im_r;

    // Next-state, beat acceptance and pulse decode.
    always_comb begin
        state_nx_s = state_r;
        pos_nx_s   = pos_r;
        timer_nx_s = {TMR_W{1'b0}};
        fwd_s      = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        drop_s     = 1'b0;
        sop_beat_s = in_if.valid & in_if.sop;
        det_eop_s  = det_src_valid & det_src_eop;

        case (state_r)
            ST_IDLE: begin
                // A sop only counts as a drop while we are being asked to run.
                if (enable) begin
                    state_nx_s = ST_CLEAR;
                    drop_s     = sop_beat_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                drop_s     = sop_beat_s;
                state_nx_s = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_nx_s = ST_IDLE;
                end else if (sop_beat_s) begin
                    fwd_s      = 1'b1;
                    pos_nx_s   = POS_ONE;
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_LOAD: begin
                // A sop anywhere inside the frame is malformed, including the
                // last beat; the offending beat is never forwarded.
                if (in_if.valid) begin
                    if (!in_if.sop && !in_if.eop && (pos_r < POS_LAST)) begin
                        fwd_s    = 1'b1;
                        pos_nx_s = pos_r + POS_ONE;
                    end else if (!in_if.sop && in_if.eop && (pos_r == POS_LAST)) begin
                        fwd_s      = 1'b1;
                        state_nx_s = ST_DRAIN;
                    end else begin
                        err_s      = 1'b1;
                        state_nx_s = ST_CLEAR;
                    end
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                drop_s = sop_beat_s;
                // The detector report takes priority over a same-cycle timeout.
                if (det_eop_s) begin
                    done_s     = 1'b1;
                    state_nx_s = enable ? ST_CLEAR : ST_IDLE;
                end else if (timer_r == TMR_LAST) begin
                    err_s      = 1'b1;
                    state_nx_s = enable ? ST_CLEAR : ST_IDLE;
                end else begin
                    timer_nx_s = timer_r + TMR_ONE;
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; det_reset/busy follow the new state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            pos_r        <= {POS_W{1'b0}};
            timer_r      <= {TMR_W{1'b0}};
            det_reset_r  <= 1'b1;
            busy_r       <= 1'b0;
            batch_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            frame_drop_r <= 1'b0;
            det_sop_r    <= 1'b0;
            det_eop_r    <= 1'b0;
            det_valid_r  <= 1'b0;
            det_re_r     <= {DATA_WIDTH{1'b0}};
            det_im_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            pos_r        <= pos_nx_s;
            timer_r      <= timer_nx_s;
            det_reset_r  <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_CLEAR);
            busy_r       <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_DRAIN);
            batch_done_r <= done_s;
            frame_err_r  <= err_s;
            frame_drop_r <= drop_s;
            det_valid_r  <= fwd_s;
            det_sop_r    <= fwd_s & in_if.sop;
            det_eop_r    <= fwd_s & in_if.eop;
            det_re_r     <= fwd_s ? in_if.re : {DATA_WIDTH{1'b0}};
            det_im_r     <= fwd_s ? in_if.im : {DATA_WIDTH{1'b0}};
        end
    end

    assign det_reset    = det_reset_r;
    assign busy         = busy_r;
    assign batch_done   = batch_done_r;
    assign frame_err    = frame_err_r;
    assign frame_drop   = frame_drop_r;
    assign det_if.sop   = det_sop_r;
    assign det_if.eop   = det_eop_r;
    assign det_if.valid = det_valid_r;
    assign det_if.re    = det_re_r;
    assign det_if.im    = det_im_r;

`ifdef PEAK_BATCH_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_r;
    logic [CNT_WIDTH-1:0] drop_cnt_r;
    logic [CNT_WIDTH-1:0] err_cnt_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating statistics; updated on the same edge that raises each pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= {CNT_WIDTH{1'b0}};
            drop_cnt_r  <= {CNT_WIDTH{1'b0}};
            err_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            frame_cnt_r <= done_s ? sat_inc(frame_cnt_r) : frame_cnt_r;
            drop_cnt_r  <= drop_s ? sat_inc(drop_cnt_r)  : drop_cnt_r;
            err_cnt_r   <= err_s  ? sat_inc(err_cnt_r)   : err_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
    assign drop_cnt  = drop_cnt_r;
    assign err_cnt   = err_cnt_r;
`endif

endmodule

// File: tb/tb_peak_batch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_peak_batch_ctrl
// Directed bench for peak_batch_ctrl. Forwarded beats are predicted when each
// input beat is driven and popped from a queue as det_valid beats appear.
// -----------------------------------------------------------------------------
module tb_peak_batch_ctrl;
    localparam int BS = 1024;
    localparam int DW = 20;
    localparam int DT = 4096;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic det_reset;
    logic det_src_valid;
    logic det_src_eop;
    logic busy;
    logic batch_done;
    logic frame_err;
    logic frame_drop;
`ifdef PEAK_BATCH_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
`endif

    peak_batch_ctrl_if #(.DATA_WIDTH(DW)) in_if ();
    peak_batch_ctrl_if #(.DATA_WIDTH(DW)) det_if ();

    peak_batch_ctrl #(
        .BATCH_SIZE    (BS),
        .DATA_WIDTH    (DW),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .in_if         (in_if),
        .det_if        (det_if),
        .det_reset     (det_reset),
        .det_src_valid (det_src_valid),
        .det_src_eop   (det_src_eop),
        .busy          (busy),
        .batch_done    (batch_done),
        .frame_err     (frame_err),
        .frame_drop    (frame_drop)
`ifdef PEAK_BATCH_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt),
        .err_cnt       (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_n    = 0;
    int err_n     = 0;
    int drop_n    = 0;
    int d_done, d_err, d_drop;
    logic [2*DW+1:0] exp_q[$];
    logic [2*DW+1:0] exp_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        d_done = done_n;
        d_err  = err_n;
        d_drop = drop_n;
    endtask

    task automatic det_eop_pulse();
        det_src_valid = 1'b1;
        det_src_eop   = 1'b1;
        tick();
        det_src_valid = 1'b0;
        det_src_eop   = 1'b0;
    endtask

    // Drives n beats (sop on first, eop on last); the first n_fwd are expected
    // at the detector. enable drops on beat en_off_at (negative: never).
    task automatic send_frame(input int n, input int n_fwd, input int en_off_at,
                              input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            in_if.valid = 1'b1;
            in_if.sop   = (i == 0);
            in_if.eop   = (i == n - 1);
            in_if.re    = {tag, 12'(i)};
            in_if.im    = ~{tag, 12'(i)};
            if (i == en_off_at) enable = 1'b0;
            if (i < n_fwd) exp_q.push_back({in_if.sop, in_if.eop, in_if.re, in_if.im});
            tick();
            if (i == 0 && n_fwd > 0) check("fwd_latency_sop", 64'(det_if.valid & det_if.sop), 64'd1);
        end
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
    endtask

    // Scoreboard and pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (det_if.valid === 1'b1) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("beat_data", 64'({det_if.sop, det_if.eop, det_if.re, det_if.im}), 64'(exp_beat));
                end
            end
            if (batch_done === 1'b1) done_n++;
            if (frame_err === 1'b1) err_n++;
            if (frame_drop === 1'b1) drop_n++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0;
        in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
        in_if.re = '0; in_if.im = '0;
        det_src_valid = 1'b0; det_src_eop = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_det_reset", 64'(det_reset), 64'd1);
        check("rst_det_valid", 64'(det_if.valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({batch_done, frame_err, frame_drop}), 64'd0);
`ifdef PEAK_BATCH_STATS_EN
        check("rst_stats", 64'({frame_cnt, drop_cnt, err_cnt}), 64'd0);
`endif
        reset_n = 1'b1; enable = 1'b1;
        tick();
        check("clear_det_reset", 64'(det_reset), 64'd1);
        tick();
        check("armed_det_reset", 64'(det_reset), 64'd0);

        // 1: clean frame, report 50 cycles later
        snap();
        send_frame(BS, BS, -1, 8'h01);
        check("t1_busy", 64'(busy), 64'd1);
        repeat (49) tick();
        det_eop_pulse();
        check("t1_done", 64'(batch_done), 64'd1);
        check("t1_clear", 64'(det_reset), 64'd1);
        tick();
        check("t1_done_once", 64'(batch_done), 64'd0);
        check("t1_clear_1cyc", 64'(det_reset), 64'd0);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);
        check("t1_done_cnt", 64'(done_n - d_done), 64'd1);

        // 2: early eop on beat 500, then a clean frame
        snap();
        send_frame(501, 500, -1, 8'h02);
        check("t2_err", 64'(frame_err), 64'd1);
        check("t2_clear", 64'(det_reset), 64'd1);
        tick();
        check("t2_err_once", 64'(frame_err), 64'd0);
        send_frame(BS, BS, -1, 8'h03);
        repeat (20) tick();
        det_eop_pulse();
        check("t2_done", 64'(batch_done), 64'd1);
        tick();
        check("t2_err_cnt", 64'(err_n - d_err), 64'd1);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // 3: second frame during DRAIN is dropped, third accepted
        snap();
        send_frame(BS, BS, -1, 8'h04);
        send_frame(BS, 0, -1, 8'h05);
        check("t3_drop_cnt", 64'(drop_n - d_drop), 64'd1);
        det_eop_pulse();
        check("t3_done_a", 64'(batch_done), 64'd1);
        tick();
        send_frame(BS, BS, -1, 8'h06);
        repeat (5) tick();
        det_eop_pulse();
        check("t3_done_b", 64'(batch_done), 64'd1);
        tick();
        check("t3_done_cnt", 64'(done_n - d_done), 64'd2);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: drain timeout, then eop exactly on the timeout cycle
        snap();
        send_frame(BS, BS, -1, 8'h07);
        repeat (DT - 1) tick();
        check("t4_no_early_err", 64'(frame_err), 64'd0);
        tick();
        check("t4_timeout_err", 64'(frame_err), 64'd1);
        check("t4_clear", 64'(det_reset), 64'd1);
        tick();
        check("t4_armed", 64'(det_reset), 64'd0);
        send_frame(BS, BS, -1, 8'h08);
        repeat (DT - 1) tick();
        det_eop_pulse();
        check("t4_tie_done", 64'(batch_done), 64'd1);
        check("t4_tie_no_err", 64'(frame_err), 64'd0);
        tick();
        check("t4_err_cnt", 64'(err_n - d_err), 64'd1);
        check("t4_done_cnt", 64'(done_n - d_done), 64'd1);

        // 5: enable dropped mid-frame
        snap();
        send_frame(BS, BS, 300, 8'h09);
        repeat (10) tick();
        det_eop_pulse();
        check("t5_done", 64'(batch_done), 64'd1);
        check("t5_idle_reset", 64'(det_reset), 64'd1);
        check("t5_idle_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("t5_reset_held", 64'(det_reset), 64'd1);
        send_frame(4, 0, -1, 8'h0a);
        tick();
        check("t5_no_drop", 64'(drop_n - d_drop), 64'd0);
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef PEAK_BATCH_STATS_EN
        check("stats_frame", 64'(frame_cnt), 64'd6);
        check("stats_err", 64'(err_cnt), 64'd2);
        check("stats_drop", 64'(drop_cnt), 64'd1);
`endif

        // 6: reset at beat 700, then a full frame
        enable = 1'b1;
        tick();
        tick();
        check("t6_armed", 64'(det_reset), 64'd0);
        for (int i = 0; i < 700; i++) begin
            in_if.valid = 1'b1;
            in_if.sop   = (i == 0);
            in_if.eop   = 1'b0;
            in_if.re    = {8'h0b, 12'(i)};
            in_if.im    = ~{8'h0b, 12'(i)};
            exp_q.push_back({in_if.sop, in_if.eop, in_if.re, in_if.im});
            tick();
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        in_if.valid = 1'b0; in_if.sop = 1'b0;
        #1;
        check("t6_rst_valid", 64'(det_if.valid), 64'd0);
        check("t6_rst_det_reset", 64'(det_reset), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
`ifdef PEAK_BATCH_STATS_EN
        check("t6_rst_stats", 64'({frame_cnt, drop_cnt, err_cnt}), 64'd0);
`endif
        tick();
        check("t6_rst_valid_next", 64'(det_if.valid), 64'd0);
        check("t6_rst_reset_next", 64'(det_reset), 64'd1);
        check("t6_q_empty", 64'(exp_q.size()), 64'd0);
        reset_n = 1'b1;
        tick();
        tick();
        snap();
        send_frame(BS, BS, -1, 8'h0c);
        repeat (5) tick();
        det_eop_pulse();
        check("t6_done", 64'(batch_done), 64'd1);
        tick();
        check("t6_q_empty_end", 64'(exp_q.size()), 64'd0);
        check("t6_err_cnt", 64'(err_n - d_err), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
